// File: rtl/pwm_generator.sv
// pwm_generator: 8-bit PWM with a request/acknowledge ratio interface.
// A new ratio takes effect only at a period boundary, so the waveform never
// glitches. An optional per-period slew limit ramps the active ratio toward
// the requested target instead of stepping it.
module pwm_generator #(
    parameter int CLK_DIV   = 1,  // clocks per PWM tick, >= 1
    parameter int RAMP_STEP = 0   // max change of ratio_active per period, 0 = no limit
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_update,
    output logic       pwm_done,
    output logic       pwm_out,
    output logic       busy,
    output logic [7:0] ratio_active
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [8:0]      STEP9      = 9'(RAMP_STEP);
    localparam logic [7:0]      STEP8      = 8'(RAMP_STEP);

    logic [PW-1:0]     presc;
    logic [7:0]        cnt;
    logic [7:0]        target;
    logic              pending;
    logic              tick;
    logic              boundary;
    logic signed [8:0] diff;
    logic [8:0]        diff_mag;
    logic [7:0]        ratio_next;

    assign busy = pending;

    // Tick/boundary decode and the ratio the next boundary will install.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        tick       = pwm_enable && (presc == PRESC_LAST);
        boundary   = tick && (cnt == 8'd255);
        diff       = $signed({1'b0, target}) - $signed({1'b0, ratio_active});
        diff_mag   = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        ratio_next = target;
        // A step is taken only when the gap exceeds it, so the result stays in 0..255.
        if (RAMP_STEP != 0 && diff_mag > STEP9) begin
            if (diff[8]) begin
                ratio_next = ratio_active - STEP8;
            end else begin
                ratio_next = ratio_active + STEP8;
            end
        end
    end

    // Prescaler and period counter; both parked at 0 while disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            presc <= '0;
            cnt   <= '0;
        end else if (!pwm_enable) begin
            presc <= '0;
            cnt   <= '0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= cnt + 8'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Active ratio changes only at the period boundary; registered compare drives the pin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ratio_active <= '0;
            pwm_out      <= 1'b0;
        end else begin
            if (!pwm_enable) begin
                ratio_active <= '0;
            end else if (boundary) begin
                ratio_active <= ratio_next;
            end
            pwm_out <= pwm_enable && (cnt < ratio_active);
        end
    end

    // Request capture and acknowledge; a fresh request always wins over an ack
    // so that pwm_done only ever refers to the newest ratio.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            target   <= '0;
            pending  <= 1'b0;
            pwm_done <= 1'b0;
        end else if (pwm_update) begin
            target   <= pwm_ratio;
            pending  <= 1'b1;
            pwm_done <= 1'b0;
        end else if (pending && (!pwm_enable || (boundary && ratio_next == target))) begin
            pending  <= 1'b0;
            pwm_done <= 1'b1;
        end else begin
            pwm_done <= 1'b0;
        end
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Produces the motor PWM waveform that the angle-control stage steers. It accepts an 8-bit ratio through the `pwm_enable`/`pwm_ratio`/`pwm_update` request interface and returns the one-cycle `pwm_done` acknowledge that interface expects. New ratios are applied only at period boundaries, so the output never glitches. An optional per-period slew limit protects the motor driver from step changes in current.

## Interface

Parameters:
- CLK_DIV, 1: clocks per PWM tick; legal range ≥1; period = 256 × CLK_DIV clocks.
- RAMP_STEP, 0: maximum change of the active ratio per period; 0 means apply the target in one step.

Ports:
- clock  in  1  main clock
- reset_n  in  1  reset, asynchronous, active-low
- pwm_enable  in  1  level; 1 runs the generator, 0 forces the output low
- pwm_ratio  in  8  requested high-time, out of 256 ticks
- pwm_update  in  1  one-cycle pulse; captures `pwm_ratio`
- pwm_done  out  1  one-cycle pulse; the latest requested ratio is now active
- pwm_out  out  1  PWM waveform, registered
- busy  out  1  an update is pending (not yet acknowledged)
- ratio_active  out  8  ratio currently driving the output (debug)

## Operation

- **Reset.** `pwm_out`=0, `pwm_done`=0, `busy`=0, `ratio_active`=0. The internal target is 0, and the prescaler and period counter are 0.
- **Prescaler.** Counts 0..CLK_DIV-1. A tick occurs on the clock where the count equals CLK_DIV-1, and the count then returns to 0.
- **Period counter.** 8 bits, advances on each tick, wraps 255→0.
  - The boundary is the tick on which the counter goes 255→0.
- **Output.** `pwm_out` <= enable & (cnt < ratio_active).
  - Ratio 0: output constantly low.
  - Ratio 255: high for 255 of 256 ticks.
- **Update capture.** On any clock where `pwm_update`=1, target <= `pwm_ratio` and pending <= 1. A later update overwrites the target; only the latest request is acknowledged.
- **Boundary processing** (enabled), using the target and pending values registered before this cycle:
  - diff = target − ratio_active, computed as 9-bit signed.
  - RAMP_STEP=0 or |diff| ≤ RAMP_STEP: ratio_active <= target.
  - Otherwise: ratio_active moves RAMP_STEP toward the target. Saturation is inherent because the step is applied only when |diff| > RAMP_STEP, so 0..255 is never exceeded.
  - If pending is set and the new ratio_active equals the target: `pwm_done` pulses on the next clock and pending clears.
  - If the target already equals ratio_active when the update arrives, the acknowledge still waits for the next boundary.
- **Simultaneous update and boundary.** The boundary uses the old target. The new update sets pending and suppresses any acknowledge from that boundary, so `pwm_done` always refers to the newest ratio.
- **Disabled** (`pwm_enable`=0):
  - Prescaler, period counter and ratio_active are held at 0; `pwm_out` is 0 on the next clock.
  - The target is retained.
  - A pending update is acknowledged with `pwm_done` 1 clock after capture, or 1 clock after disable if it was already pending. The handshake therefore never stalls.
- **Re-enable.** Counting starts from 0 on the enable clock. ratio_active ramps from 0 toward the retained target at the boundaries that follow.
- **Reset mid-operation.** All state returns to reset values immediately. Any pending request is dropped without an acknowledge.

## Timing

- `pwm_out` lags the period counter by 1 clock (registered compare).
- Update→done latency with RAMP_STEP=0: from 1 clock up to 256×CLK_DIV+1 clocks, depending on where the request falls in the period.
- With ramping: ceil(|target − ratio_active| / RAMP_STEP) boundaries, plus 1 clock.
- `pwm_done` is exactly 1 clock wide and is never asserted in two consecutive cycles.
- `busy` rises the clock after `pwm_update` and falls in the same clock that `pwm_done` rises.
- The output changes duty only at period starts; no partial periods occur except at enable/disable.

## Test plan

- **Basic duty and acknowledge.** Reset, enable, CLK_DIV=1, RAMP_STEP=0; update ratio 64 → `pwm_done` 1 clock after the next boundary; the following periods show 64 high / 192 low clocks.
- **Extremes.** Ratio 0 → `pwm_out` never high. Ratio 255 → high 255 of 256 clocks. Ratio 128 with CLK_DIV=4 → period 1024 clocks, 512 high.
- **Ramp.** RAMP_STEP=16; from active 0, update 100 → `ratio_active` 16,32,48,64,80,96,100 on successive boundaries; a single `pwm_done` after the 100 boundary; the ramp back 100→0 behaves the same.
- **Overwrite and collision.** Update 50, then update 200 before the boundary → exactly one `pwm_done`, once active=200. An update coinciding with a boundary → no acknowledge from that boundary.
- **Disable.** Disable mid-period → `pwm_out` 0 the next clock. An update while disabled → `pwm_done` 1 clock later. Re-enable → counter restarts at 0 and the ramp restarts from 0.
- **Reset mid-ramp.** Assert reset_n low mid-ramp → all outputs 0 asynchronously; no `pwm_done` after release.
